// File: rtl/dot_product_pkg.sv
// Shared FSM encoding and width helpers for the sequential dot-product controller.
package dot_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Accumulator width: full product width plus enough headroom for LEN additions.
  function automatic int acc_width(input int width, input int len);
    return 2 * width + ((len > 1) ? $clog2(len) : 0);
  endfunction

  // Pair counter width: must be able to hold the value LEN.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len + 1) : 1;
  endfunction

endpackage

// File: rtl/seq_dot_product_ctrl_if.sv
// Bundles the operand, multiplier and result handshakes of the dot-product controller.
interface seq_dot_product_ctrl_if
  import dot_product_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
);
  localparam int ACC_W = acc_width(WIDTH, LEN);

  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_start;
  logic [2*WIDTH-1:0] mul_out;
  logic               mul_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               out_valid;
  logic               out_ready;

  // Controller side.
  modport slave (
    input  in_a, in_b, in_valid, mul_out, mul_ready, out_ready,
    output in_ready, mul_a, mul_b, mul_start, out_sum, out_valid
  );

  // Environment side: operand source, external multiplier and result sink.
  modport master (
    output in_a, in_b, in_valid, mul_out, mul_ready, out_ready,
    input  in_ready, mul_a, mul_b, mul_start, out_sum, out_valid
  );

endinterface

// File: rtl/dp_accumulator.sv
// Running sum of products plus a count of products accumulated so far.
module dp_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 18,
  parameter int LEN    = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  acc,
  output logic              last
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-value logic: clear wins over add; add zero-extends the product.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (clr) begin
      acc_d   = '0;
      count_d = '0;
    end else if (add) begin
      acc_d   = acc_q + ACC_W'(addend);
      count_d = count_q + CNT_W'(1);
    end
  end

  // Accumulator and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign acc  = acc_q;
  // The product being added now is the final one of the dot product.
  assign last = (count_q == CNT_W'(LEN - 1));

endmodule

// File: rtl/seq_dot_product_ctrl.sv
// Sequences operand pairs through an external multiplier and accumulates the products.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for an operand pair; latches it into mul_a/mul_b
// ST_START | one-cycle mul_start pulse to the multiplier
// ST_WAIT  | operands held; waits for mul_ready, then accumulates
// ST_OUT   | result presented; held until out_ready
module seq_dot_product_ctrl
  import dot_product_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
) (
  input logic                  clk,
  input logic                  rst,
  seq_dot_product_ctrl_if.slave bus
);

  localparam int ACC_W = acc_width(WIDTH, LEN);
  localparam int CNT_W = cnt_width(LEN);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             acc_add;
  logic             acc_clr;
  logic             acc_last;
  logic [ACC_W-1:0] acc;

  dp_accumulator #(
    .PROD_W (2 * WIDTH),
    .ACC_W  (ACC_W),
    .LEN    (LEN),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add    (acc_add),
    .addend (bus.mul_out),
    .acc    (acc),
    .last   (acc_last)
  );

  // Next-state, operand capture and accumulator controls. mul_ready is only
  // looked at in ST_WAIT: the multiplier leaves it high between operations.
  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_add = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mul_ready) begin
          acc_add = 1'b1;
          state_d = acc_last ? ST_OUT : ST_IDLE;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          acc_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  // Handshake outputs decode from state only, so no input reaches them combinationally.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.mul_start = (state_q == ST_START);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_sum   = acc;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule

// File: doc/seq_dot_product_ctrl.md
SEQ_DOT_PRODUCT_CTRL -- requirements
Module: seq_dot_product_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter LEN, default 4, operand pairs per dot product (LEN >= 1).
REQ-003 SHALL have localparam ACC_W = 2*WIDTH + clog2(LEN) (minimum 2*WIDTH), accumulator and result width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_a, in_b  input  WIDTH each  unsigned operand pair.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 mul_a, mul_b  output  WIDTH each  operands to the external sequential multiplier.
REQ-010 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 mul_out  input  2*WIDTH  product from the multiplier.
REQ-012 mul_ready  input  1  multiplier result-valid level.
REQ-013 out_sum  output  ACC_W  dot-product result.
REQ-014 out_valid  output  1  out_sum valid.
REQ-015 out_ready  input  1  downstream accepts result.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, OUT.
REQ-017 IDLE: in_ready=1; on in_valid SHALL register in_a/in_b into mul_a/mul_b and go to START.
REQ-018 START: mul_start=1 for exactly this one cycle; in_ready=0; next state WAIT unconditionally.
REQ-019 WAIT: mul_start=0, in_ready=0; mul_a/mul_b held stable; stay until mul_ready=1.
REQ-020 WAIT with mul_ready=1: acc <= acc + zero-extended mul_out; count <= count+1; go to OUT if the updated count equals LEN, else IDLE.
REQ-021 mul_ready SHALL be sampled only in WAIT; its level in IDLE, START or OUT SHALL be ignored (the multiplier's ready stays high between operations and falls on the edge that samples start).
REQ-022 OUT: out_valid=1, out_sum=acc, in_ready=0; on out_ready=1 SHALL clear acc and count to 0 and go to IDLE.
REQ-023 out_sum SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Accumulation SHALL be exact unsigned arithmetic; ACC_W guarantees no wrap for LEN maximal products.
REQ-025 Per-pair latency from IDLE acceptance edge to WAIT exit = 2 + multiplier latency (WIDTH cycles) cycles.
REQ-026 LEN=1 SHALL go WAIT -> OUT after the first product.
REQ-027 out_valid, in_ready, mul_start SHALL be registered or decoded purely from state (no combinational path from in_valid/out_ready/mul_ready).

Reset
REQ-028 rst=1 at any cycle, including mid-WAIT, SHALL force state IDLE, acc=0, count=0, mul_a=mul_b=0, mul_start=0, out_valid=0, out_sum=0; in_ready=1 from the first cycle after reset release.
REQ-029 A multiplier result completing after reset SHALL be ignored; the next accepted pair restarts the multiplier via mul_start.

Structure
REQ-030 FSM state encoding and the ACC_W derivation function SHALL live in a shared package dot_product_pkg.
REQ-031 The multiplier SHALL NOT be instantiated inside; it is connected at the next level up. One sub-module, dp_accumulator (acc register, count register, clear/add controls), is natural.

Verification (WIDTH=8, LEN=4, bench models multiplier with WIDTH-cycle shift-add timing)
REQ-032 Pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> out_sum=100 (0x64), out_valid once, exactly four mul_start pulses.
REQ-033 Four pairs (255,255) -> out_sum=260100 (0x3F804), no overflow in 18-bit ACC_W.
REQ-034 out_ready held low 10 cycles in OUT -> out_sum stable, in_ready=0, in_valid ignored; release -> IDLE, next dot product starts from acc=0.
REQ-035 rst pulsed in WAIT of second pair -> all outputs at reset values next cycle; new four pairs (2,3)x4 -> out_sum=24.
REQ-036 mul_ready held high in IDLE/START (stale) with in_valid gaps of 3 cycles -> no accumulation until WAIT sees mul_ready; pair (0,255)x4 -> out_sum=0.
